// File: rtl/mvu_job_sched.sv
// Arbitrates job starts from barrel harts onto one shared MVU command port.
// Round-robin hart selection, one job in flight, per-hart completion interrupt.
module mvu_job_sched #(
    parameter int unsigned NUM_HARTS      = 8,
    parameter int unsigned HART_CNT_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_HARTS-1:0]      start_i,
    output logic                      cmd_valid_o,
    input  logic                      cmd_ready_i,
    output logic [HART_CNT_WIDTH-1:0] cmd_hart_o,
    input  logic                      mvu_done_i,
    output logic [NUM_HARTS-1:0]      mvu_irq_o,
    output logic [NUM_HARTS-1:0]      pending_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int unsigned IDX_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_IRQ
    } state_t;

    state_t                    r_state;
    logic [NUM_HARTS-1:0]      r_pending;
    logic [NUM_HARTS-1:0]      r_irq;
    logic [HART_CNT_WIDTH-1:0] r_hart;
    logic [HART_CNT_WIDTH-1:0] r_last;
    logic                      r_valid;
    logic                      r_busy;
    logic                      r_err;

    logic                      w_found;
    logic [HART_CNT_WIDTH-1:0] w_sel;
    int unsigned               w_idx;
    logic                      w_hs;
    logic [NUM_HARTS-1:0]      w_hot;
    logic [NUM_HARTS-1:0]      w_clr;
    logic [NUM_HARTS-1:0]      w_dup;
    logic                      w_bad_done;

    // Round-robin search starting just after the last granted hart.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int unsigned i = 1; i <= NUM_HARTS; i++) begin
            w_idx = (32'(r_last) + i) % NUM_HARTS;
            if (!w_found && r_pending[IDX_W'(w_idx)]) begin
                w_found = 1'b1;
                w_sel   = HART_CNT_WIDTH'(w_idx);
            end
        end
    end

    assign w_hs       = (r_state == S_ISSUE) && cmd_ready_i;
    assign w_hot      = NUM_HARTS'(1) << r_hart;
    assign w_clr      = w_hs ? w_hot : '0;
    // A start landing on the grant cycle re-queues and is not a duplicate.
    assign w_dup      = start_i & r_pending & ~w_clr;
    assign w_bad_done = mvu_done_i && (r_state != S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_irq     <= '0;
            r_hart    <= '0;
            r_last    <= HART_CNT_WIDTH'(NUM_HARTS - 1);
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | start_i;
            r_irq     <= '0;
            if ((|w_dup) || w_bad_done) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_hart  <= w_sel;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready_i) begin
                        r_valid <= 1'b0;
                        r_last  <= r_hart;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (mvu_done_i) begin
                        r_irq   <= w_hot;
                        r_state <= S_IRQ;
                    end
                end
                S_IRQ: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid_o = r_valid;
    assign cmd_hart_o  = r_hart;
    assign mvu_irq_o   = r_irq;
    assign pending_o   = r_pending;
    assign busy_o      = r_busy;
    assign err_o       = r_err;

endmodule

// File: tb/tb_mvu_job_sched.sv
// Self-checking bench for mvu_job_sched: directed scenarios plus randomized
// job traffic compared against a pending-set / round-robin reference model.
module tb_mvu_job_sched;

    localparam int unsigned NH = 8;
    localparam int unsigned HW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NH-1:0] start_i;
    logic          cmd_valid_o;
    logic          cmd_ready_i;
    logic [HW-1:0] cmd_hart_o;
    logic          mvu_done_i;
    logic [NH-1:0] mvu_irq_o;
    logic [NH-1:0] pending_o;
    logic          busy_o;
    logic          err_o;

    int n_pass  = 0;
    int n_total = 0;

    mvu_job_sched #(.NUM_HARTS(NH), .HART_CNT_WIDTH(HW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .cmd_valid_o (cmd_valid_o),
        .cmd_ready_i (cmd_ready_i),
        .cmd_hart_o  (cmd_hart_o),
        .mvu_done_i  (mvu_done_i),
        .mvu_irq_o   (mvu_irq_o),
        .pending_o   (pending_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        start_i     = '0;
        cmd_ready_i = 1'b0;
        mvu_done_i  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference rule: first requesting hart strictly after the last grant, wrapping.
    function automatic int rr_pick(input logic [NH-1:0] pend, input int last);
        for (int k = 1; k <= int'(NH); k++) begin
            if (pend[(last + k) % int'(NH)]) return (last + k) % int'(NH);
        end
        return -1;
    endfunction

    function automatic logic [NH-1:0] onehot(input int h);
        logic [NH-1:0] v;
        v = '0;
        if (h >= 0) v[h] = 1'b1;
        return v;
    endfunction

    // Services one job end to end; run_start is pulsed while the job is running.
    task automatic do_job(input int rdly, input int ddly, input logic [NH-1:0] run_start,
                          output int hart, output logic [NH-1:0] irq, output bit to);
        int w;
        to   = 1'b0;
        hart = -1;
        irq  = '0;
        w    = 0;
        while (cmd_valid_o !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        if (cmd_valid_o !== 1'b1) begin
            to = 1'b1;
            return;
        end
        hart = int'(cmd_hart_o);
        repeat (rdly) tick();
        cmd_ready_i = 1'b1;
        tick();
        cmd_ready_i = 1'b0;
        start_i = run_start;
        tick();
        start_i = '0;
        repeat (ddly) tick();
        mvu_done_i = 1'b1;
        tick();
        mvu_done_i = 1'b0;
        irq = mvu_irq_o;
        tick();
    endtask

    task automatic wait_valid(output bit to);
        int w;
        w  = 0;
        to = 1'b0;
        while (cmd_valid_o !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        if (cmd_valid_o !== 1'b1) to = 1'b1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        start_i     = '0;
        cmd_ready_i = 1'b0;
        mvu_done_i  = 1'b0;
        #2;
        n_total++;
        if ({cmd_valid_o, cmd_hart_o, mvu_irq_o, pending_o, busy_o, err_o} !== '0)
            $display("FAIL reset_outputs: got valid=%b hart=%0d irq=%h pend=%h busy=%b err=%b, want all 0",
                     cmd_valid_o, cmd_hart_o, mvu_irq_o, pending_o, busy_o, err_o);
        else n_pass++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_job();
        do_reset();
        start_i = 8'h04;
        tick();
        start_i = '0;
        n_total++;
        if (pending_o !== 8'h04 || cmd_valid_o !== 1'b0)
            $display("FAIL single_t1: pend=%h valid=%b, want pend=04 valid=0", pending_o, cmd_valid_o);
        else n_pass++;
        cmd_ready_i = 1'b1;
        tick();
        n_total++;
        if (cmd_valid_o !== 1'b1 || cmd_hart_o !== 3'd2 || busy_o !== 1'b1)
            $display("FAIL single_t2: valid=%b hart=%0d busy=%b, want 1/2/1", cmd_valid_o, cmd_hart_o, busy_o);
        else n_pass++;
        tick();
        cmd_ready_i = 1'b0;
        n_total++;
        if (cmd_valid_o !== 1'b0 || pending_o !== 8'h00 || busy_o !== 1'b1)
            $display("FAIL single_run: valid=%b pend=%h busy=%b, want 0/00/1", cmd_valid_o, pending_o, busy_o);
        else n_pass++;
        repeat (7) tick();
        mvu_done_i = 1'b1;
        tick();
        mvu_done_i = 1'b0;
        n_total++;
        if (mvu_irq_o !== 8'h04)
            $display("FAIL single_irq: irq=%h, want 04", mvu_irq_o);
        else n_pass++;
        tick();
        n_total++;
        if (mvu_irq_o !== 8'h00 || busy_o !== 1'b0 || err_o !== 1'b0)
            $display("FAIL single_after: irq=%h busy=%b err=%b, want 00/0/0", mvu_irq_o, busy_o, err_o);
        else n_pass++;
    endtask

    task automatic test_fairness();
        logic [NH-1:0] m_pend;
        logic [NH-1:0] irq;
        int            m_last;
        int            exp_h;
        int            h;
        bit            to;
        do_reset();
        m_pend  = 8'hFF;
        m_last  = NH - 1;
        start_i = 8'hFF;
        tick();
        start_i = '0;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) begin
                start_i = 8'h21;
                m_pend  = 8'h21;
                tick();
                start_i = '0;
            end
            exp_h = rr_pick(m_pend, m_last);
            do_job(0, 0, '0, h, irq, to);
            n_total++;
            if (to || h != exp_h || irq !== onehot(exp_h))
                $display("FAIL fair_job%0d: hart=%0d irq=%h timeout=%b, want hart=%0d irq=%h",
                         k, h, irq, to, exp_h, onehot(exp_h));
            else n_pass++;
            m_pend[exp_h] = 1'b0;
            m_last        = exp_h;
        end
    endtask

    task automatic test_backpressure();
        bit to;
        do_reset();
        start_i = 8'h08;
        tick();
        start_i = '0;
        wait_valid(to);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_total++;
            if (to || cmd_valid_o !== 1'b1 || cmd_hart_o !== 3'd3 || pending_o !== 8'h08)
                $display("FAIL bp_hold%0d: valid=%b hart=%0d pend=%h, want 1/3/08", k, cmd_valid_o, cmd_hart_o, pending_o);
            else n_pass++;
        end
        cmd_ready_i = 1'b1;
        tick();
        cmd_ready_i = 1'b0;
        n_total++;
        if (cmd_valid_o !== 1'b0 || pending_o !== 8'h00 || busy_o !== 1'b1)
            $display("FAIL bp_handshake: valid=%b pend=%h busy=%b, want 0/00/1", cmd_valid_o, pending_o, busy_o);
        else n_pass++;
        mvu_done_i = 1'b1;
        tick();
        mvu_done_i = 1'b0;
        n_total++;
        if (mvu_irq_o !== 8'h08)
            $display("FAIL bp_irq: irq=%h, want 08", mvu_irq_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_requeue();
        logic [NH-1:0] irq;
        int            h;
        bit            to;
        do_reset();
        start_i = 8'h28;
        tick();
        start_i = '0;
        wait_valid(to);
        n_total++;
        if (to || cmd_hart_o !== 3'd3)
            $display("FAIL rq_first: hart=%0d timeout=%b, want 3", cmd_hart_o, to);
        else n_pass++;
        cmd_ready_i = 1'b1;
        start_i     = 8'h08;
        tick();
        cmd_ready_i = 1'b0;
        start_i     = '0;
        n_total++;
        if (pending_o !== 8'h28)
            $display("FAIL rq_pending: pend=%h, want 28", pending_o);
        else n_pass++;
        mvu_done_i = 1'b1;
        tick();
        mvu_done_i = 1'b0;
        tick();
        do_job(0, 1, '0, h, irq, to);
        n_total++;
        if (to || h != 5 || irq !== 8'h20)
            $display("FAIL rq_second: hart=%0d irq=%h, want 5/20", h, irq);
        else n_pass++;
        do_job(0, 1, '0, h, irq, to);
        n_total++;
        if (to || h != 3 || irq !== 8'h08)
            $display("FAIL rq_third: hart=%0d irq=%h, want 3/08", h, irq);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [NH-1:0] irq;
        int            h;
        bit            seen;
        bit            to;
        do_reset();
        mvu_done_i = 1'b1;
        tick();
        mvu_done_i = 1'b0;
        n_total++;
        if (err_o !== 1'b1 || busy_o !== 1'b0)
            $display("FAIL err_done_idle: err=%b busy=%b, want 1/0", err_o, busy_o);
        else n_pass++;
        tick();
        n_total++;
        if (err_o !== 1'b1 || mvu_irq_o !== 8'h00)
            $display("FAIL err_sticky: err=%b irq=%h, want 1/00", err_o, mvu_irq_o);
        else n_pass++;

        do_reset();
        start_i = 8'h02;
        tick();
        n_total++;
        if (err_o !== 1'b0)
            $display("FAIL dup_first: err=%b, want 0", err_o);
        else n_pass++;
        tick();
        start_i = '0;
        n_total++;
        if (err_o !== 1'b1 || pending_o !== 8'h02)
            $display("FAIL dup_second: err=%b pend=%h, want 1/02", err_o, pending_o);
        else n_pass++;
        do_job(0, 0, '0, h, irq, to);
        n_total++;
        if (to || h != 1 || irq !== 8'h02)
            $display("FAIL dup_job: hart=%0d irq=%h, want 1/02", h, irq);
        else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cmd_valid_o === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (seen || pending_o !== 8'h00 || err_o !== 1'b1)
            $display("FAIL dup_single: extra_issue=%b pend=%h err=%b, want 0/00/1", seen, pending_o, err_o);
        else n_pass++;
    endtask

    task automatic test_reset_in_run();
        logic [NH-1:0] irq;
        int            h;
        bit            to;
        do_reset();
        start_i = 8'h40;
        tick();
        start_i = '0;
        wait_valid(to);
        cmd_ready_i = 1'b1;
        tick();
        cmd_ready_i = 1'b0;
        n_total++;
        if (to || busy_o !== 1'b1)
            $display("FAIL rr_run: busy=%b timeout=%b, want busy=1", busy_o, to);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({cmd_valid_o, cmd_hart_o, mvu_irq_o, pending_o, busy_o, err_o} !== '0)
            $display("FAIL rr_async: valid=%b hart=%0d irq=%h pend=%h busy=%b err=%b, want all 0",
                     cmd_valid_o, cmd_hart_o, mvu_irq_o, pending_o, busy_o, err_o);
        else n_pass++;
        tick();
        rst        = 1'b0;
        mvu_done_i = 1'b1;
        tick();
        mvu_done_i = 1'b0;
        tick();
        n_total++;
        if (err_o !== 1'b1 || mvu_irq_o !== 8'h00)
            $display("FAIL rr_late_done: err=%b irq=%h, want 1/00", err_o, mvu_irq_o);
        else n_pass++;
        start_i = 8'h41;
        tick();
        start_i = '0;
        do_job(0, 0, '0, h, irq, to);
        n_total++;
        if (to || h != 0 || irq !== 8'h01)
            $display("FAIL rr_first_grant: hart=%0d irq=%h, want 0/01", h, irq);
        else n_pass++;
        do_job(0, 0, '0, h, irq, to);
        n_total++;
        if (to || h != 6 || irq !== 8'h40)
            $display("FAIL rr_second_grant: hart=%0d irq=%h, want 6/40", h, irq);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [NH-1:0] m_pend;
        logic [NH-1:0] run_start;
        logic [NH-1:0] irq;
        logic [NH-1:0] mask;
        int            m_last;
        int            exp_h;
        int            h;
        bit            to;
        do_reset();
        m_pend = '0;
        m_last = NH - 1;
        for (int j = 0; j < 40; j++) begin
            if (m_pend == '0) begin
                mask    = NH'($urandom_range(1, 255));
                start_i = mask;
                tick();
                start_i = '0;
                m_pend  = mask;
            end
            n_total++;
            if (pending_o !== m_pend)
                $display("FAIL rand_pend%0d: pend=%h, want %h", j, pending_o, m_pend);
            else n_pass++;
            exp_h     = rr_pick(m_pend, m_last);
            run_start = NH'($urandom & $urandom) & ~(m_pend & ~onehot(exp_h));
            do_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), run_start, h, irq, to);
            n_total++;
            if (to || h != exp_h || irq !== onehot(exp_h))
                $display("FAIL rand_job%0d: hart=%0d irq=%h timeout=%b, want hart=%0d irq=%h",
                         j, h, irq, to, exp_h, onehot(exp_h));
            else n_pass++;
            m_pend = (m_pend & ~onehot(exp_h)) | run_start;
            m_last = exp_h;
        end
        n_total++;
        if (err_o !== 1'b0)
            $display("FAIL rand_err: err=%b, want 0", err_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_fairness();
        test_backpressure();
        test_requeue();
        test_errors();
        test_reset_in_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/mvu_job_sched.md
MVU_JOB_SCHED -- requirements
Module: mvu_job_sched

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 8, number of barrel harts sharing the MVU command port.
REQ-002 SHALL have parameter HART_CNT_WIDTH, default pito_pkg::HART_CNT_WIDTH (3), width of a hart index.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_i  input  NUM_HARTS  per-hart one-cycle job-start pulse from the per-hart CSR files.
REQ-006 SHALL have port cmd_valid_o  output  1  job command to the shared MVU is valid.
REQ-007 SHALL have port cmd_ready_i  input  1  MVU accepts the command.
REQ-008 SHALL have port cmd_hart_o  output  HART_CNT_WIDTH  hart whose CSR configuration the MVU shall use.
REQ-009 SHALL have port mvu_done_i  input  1  one-cycle pulse: MVU finished the running job.
REQ-010 SHALL have port mvu_irq_o  output  NUM_HARTS  per-hart one-cycle completion interrupt.
REQ-011 SHALL have port pending_o  output  NUM_HARTS  per-hart queued-request bits.
REQ-012 SHALL have port busy_o  output  1  state is not IDLE.
REQ-013 SHALL have port err_o  output  1  sticky protocol error flag.

Function
REQ-014 SHALL hold one pending bit per hart; start_i[h]=1 sets pending[h] on the next edge.
REQ-015 SHALL ignore start_i[h] when pending[h] is already 1 (no counting) and SHALL set err_o.
REQ-016 SHALL implement the FSM states IDLE, ISSUE, RUN and IRQ.
REQ-017 IDLE: when any pending bit is 1, SHALL select a hart round-robin, register it into cmd_hart_o, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-018 The round-robin search SHALL start at last_grant+1, wrap from NUM_HARTS-1 to 0, and pick the first pending hart.
REQ-019 ISSUE: SHALL drive cmd_valid_o=1 and hold cmd_hart_o stable until cmd_valid_o&cmd_ready_i.
REQ-020 On the ISSUE handshake, SHALL clear pending[cmd_hart_o], update last_grant=cmd_hart_o, and go to RUN.
REQ-021 RUN: SHALL wait for mvu_done_i, then go to IRQ.
REQ-022 IRQ: SHALL assert mvu_irq_o[cmd_hart_o]=1 for exactly one cycle, keep all other irq bits 0, then go to IDLE.
REQ-023 Latency: start_i at cycle t SHALL give pending_o at t+1 and cmd_valid_o at t+2 when idle.
REQ-024 Latency: mvu_done_i at cycle t SHALL give mvu_irq_o at t+1.
REQ-025 If a set (start_i) and a clear (grant) hit the same pending bit in one cycle, the set SHALL win and the bit SHALL stay 1 (re-queue).
REQ-026 mvu_done_i outside RUN SHALL be ignored and SHALL set err_o.
REQ-027 cmd_ready_i outside ISSUE SHALL be ignored.
REQ-028 A start_i for the hart currently in RUN SHALL queue normally; that hart SHALL be serviced again only via round-robin.
REQ-029 Jobs SHALL never overlap: at most one hart is in ISSUE/RUN/IRQ at a time.
REQ-030 err_o SHALL clear only on reset.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, pending=0, cmd_valid_o=0, cmd_hart_o=0, mvu_irq_o=0, busy_o=0, err_o=0 and last_grant=NUM_HARTS-1, so hart 0 has first priority.
REQ-032 Reset asserted mid-job (ISSUE or RUN) SHALL drop the job and raise no irq; a later mvu_done_i SHALL set err_o.

Verification
REQ-033 Single job: start_i=8'h04 at t, cmd_ready_i=1 -> pending_o=8'h04 at t+1; cmd_valid_o=1 with cmd_hart_o=2 at t+2; mvu_done_i at t+10 -> mvu_irq_o=8'h04 at t+11 only.
REQ-034 Fairness: start_i=8'hFF with immediate done each job -> grant order 0,1,...,7; then re-request 0 and 5 -> order 5 is not required first; the order SHALL be 0 then 5, since the search starts after last_grant=7.
REQ-035 Backpressure: cmd_ready_i=0 for 5 cycles in ISSUE -> cmd_valid_o held at 1, cmd_hart_o stable, pending bit still 1 until the handshake.
REQ-036 Boundary: start_i[3] in the same cycle as the grant of hart 3 -> pending_o[3] stays 1 and hart 3 is re-issued after the others.
REQ-037 Errors: mvu_done_i in IDLE -> err_o=1 sticky, no irq; duplicate start_i[1] while pending -> err_o=1 and a single job is issued.
REQ-038 Reset in RUN for hart 6 -> all outputs 0 the same cycle; next start_i=8'h41 -> hart 0 is granted first.
